// File: rtl/puf_pkg.sv
// Shared types and helpers for the multi-channel RO frequency meter.
// Imported by the meter top, its interface and the bench.
package puf_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_e;

  localparam int DEF_N_CH   = 2;
  localparam int DEF_CNT_W  = 20;
  localparam int DEF_WIN_W  = 24;
  localparam int DEF_SETTLE = 16;

  // Wide enough for any sane CNT_W; counts are zero-extended into it.
  localparam int CMP_W = 64;

  function automatic logic pair_gt(
    input logic [CMP_W-1:0] a,
    input logic [CMP_W-1:0] b
  );
    return a > b;
  endfunction

endpackage

// File: rtl/puf_ro_meter_if.sv
// Control/result bundle between the RO meter and its readout logic.
// master = requester/readout side, slave = the meter.
interface puf_ro_meter_if
  import puf_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
);

  logic                    start;
  logic                    abort;
  logic [WIN_W-1:0]        win_len;
  logic                    busy;
  logic                    done;
  logic [N_CH*CNT_W-1:0]   counts;
  logic [N_CH-1:0]         sat;
  logic [N_CH/2-1:0]       resp;

  modport master (
    output start, abort, win_len,
    input  busy, done, counts, sat, resp
  );

  modport slave (
    input  start, abort, win_len,
    output busy, done, counts, sat, resp
  );

endinterface

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser plus edge flop for one asynchronous RO input.
// rise is a one-cycle pulse per synchronised low-to-high transition.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/puf_ro_meter.sv
// Multi-channel ring-oscillator frequency meter: settle, count over a
// clk window, latch counts/saturation and derive pairwise response bits.
module puf_ro_meter
  import puf_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int SETTLE_CYC = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] ro_in,
  output logic [N_CH-1:0] ro_en,
  puf_ro_meter_if.slave   bus
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                state_q;
  logic [WIN_W-1:0]      win_q;
  logic [SET_W-1:0]      set_q;
  logic [CNT_W-1:0]      cnt_q [N_CH];
  logic [CNT_W-1:0]      cnt_d [N_CH];
  logic [N_CH-1:0]       satw_q;
  logic [N_CH-1:0]       satw_d;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       ro_en_q;
  logic [N_CH-1:0]       sat_q;
  logic [N_CH/2-1:0]     resp_q;
  logic [N_CH/2-1:0]     resp_d;
  logic [N_CH*CNT_W-1:0] counts_q;
  logic [N_CH*CNT_W-1:0] counts_d;
  logic                  busy_q;
  logic                  done_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    ro_edge_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (ro_in[i]),
      .rise     (rise[i])
    );
  end

  // Next working counts include the current cycle's rises, so the
  // last MEASURE cycle is folded into the latched result.
  always_comb begin
    counts_d = '0;
    resp_d   = '0;
    satw_d   = satw_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rise[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          satw_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      counts_d[i*CNT_W +: CNT_W] = cnt_d[i];
    end
    for (int k = 0; k < N_CH/2; k++) begin
      resp_d[k] = pair_gt(CMP_W'(cnt_d[2*k]),
                          CMP_W'(cnt_d[2*k+1]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      set_q    <= '0;
      satw_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      ro_en_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      counts_q <= '0;
      sat_q    <= '0;
      resp_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            win_q   <= (bus.win_len == '0) ? WIN_W'(1)
                                           : bus.win_len;
            set_q   <= SET_W'(SETTLE_CYC - 1);
            satw_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
              cnt_q[i] <= '0;
            end
            ro_en_q <= '1;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.abort) begin
            ro_en_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (set_q == '0) begin
            state_q <= S_MEASURE;
          end else begin
            set_q <= set_q - SET_W'(1);
          end
        end
        S_MEASURE: begin
          if (bus.abort) begin
            ro_en_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q  <= cnt_d;
            satw_q <= satw_d;
            if (win_q == WIN_W'(1)) begin
              ro_en_q  <= '0;
              done_q   <= 1'b1;
              counts_q <= counts_d;
              sat_q    <= satw_d;
              resp_q   <= resp_d;
              state_q  <= S_DONE;
            end else begin
              win_q <= win_q - WIN_W'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ro_en      = ro_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.counts = counts_q;
  assign bus.sat    = sat_q;
  assign bus.resp   = resp_q;

endmodule
